// File: rtl/mm_pkg.sv
// Shared constants and FSM state encoding for the matrix-multiplier operand driver.
package mm_pkg;

    localparam int MM_DW      = 8;
    localparam int MM_RW      = 2 * MM_DW + 1;
    localparam int MM_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } mm_state_e;

endpackage

// File: rtl/mm_timeout_counter.sv
// Free-running wait timer: cleared on entry to the wait phase, flags TIMEOUT-1.
module mm_timeout_counter
    import mm_pkg::*;
#(
    parameter int TIMEOUT = MM_TIMEOUT,
    parameter int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [TW-1:0] count;

    // The owner stops enabling once tc is seen, so the count never wraps.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mm_operand_driver.sv
// Initiator for one MatrixMultiplier: takes a four-operand request, serialises it over
// two START cycles, waits for OUT_STROBE (or a timeout) and holds the result for a consumer.
module mm_operand_driver
    import mm_pkg::*;
#(
    parameter int DW      = MM_DW,
    parameter int RW      = MM_RW,
    parameter int TIMEOUT = MM_TIMEOUT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [DW-1:0] REQ_A0,
    input  logic [DW-1:0] REQ_B0,
    input  logic [DW-1:0] REQ_A1,
    input  logic [DW-1:0] REQ_B1,
    output logic          MM_START,
    output logic [DW-1:0] MM_A,
    output logic [DW-1:0] MM_B,
    input  logic [RW-1:0] MM_OUT,
    input  logic          MM_STROBE,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic [RW-1:0] RES_DATA,
    output logic          RES_ERR,
    output logic [2:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid/ready here are decoded from registered state only, never from the inputs.

    mm_state_e     state, state_n;
    logic [DW-1:0] op_a0, op_b0, op_a1, op_b1;
    logic [RW-1:0] res_data_q;
    logic          res_err_q;
    logic          timer_clr, timer_en, timer_tc;

    mm_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (timer_clr),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_comb begin
        state_n   = state;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            IDLE:  if (REQ_VALID) state_n = SEND0;
            SEND0: state_n = SEND1;
            SEND1: begin
                state_n   = WAIT;
                timer_clr = 1'b1;
            end
            // A strobe in the terminal-count cycle still counts as a real result.
            WAIT: begin
                timer_en = 1'b1;
                if (MM_STROBE || timer_tc) state_n = HOLD;
            end
            HOLD:  if (RES_READY) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = 1'b0;
        MM_START  = 1'b0;
        MM_A      = '0;
        MM_B      = '0;
        RES_VALID = 1'b0;
        case (state)
            IDLE:  REQ_READY = 1'b1;
            SEND0: begin
                MM_START = 1'b1;
                MM_A     = op_a0;
                MM_B     = op_b0;
            end
            SEND1: begin
                MM_START = 1'b1;
                MM_A     = op_a1;
                MM_B     = op_b1;
            end
            HOLD:  RES_VALID = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            op_a0      <= '0;
            op_b0      <= '0;
            op_a1      <= '0;
            op_b1      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && REQ_VALID) begin
                op_a0 <= REQ_A0;
                op_b0 <= REQ_B0;
                op_a1 <= REQ_A1;
                op_b1 <= REQ_B1;
            end
            // Result registers only move in WAIT, so stray strobes elsewhere are harmless.
            if (state == WAIT) begin
                if (MM_STROBE) begin
                    res_data_q <= MM_OUT;
                    res_err_q  <= 1'b0;
                end else if (timer_tc) begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
            end
        end
    end

    assign RES_DATA  = res_data_q;
    assign RES_ERR   = res_err_q;
    assign dbg_state = state;

endmodule

// File: doc/mm_operand_driver.md
Name: mm_operand_driver

Overview:
- Initiator for the matrix multiplier's START/A/B/OUT/OUT_STROBE interface.
- Accepts one four-operand request (A0, B0, A1, B1) over a valid/ready handshake.
- Serialises the request onto the multiplier port over two START cycles, waits for OUT_STROBE, then returns the 17-bit signed result (or a timeout error) over a valid/ready handshake.
- Sits between a host or test sequencer and one MatrixMultiplier instance.

Parameters:
- DW, 8, operand width (signed).
- RW, 17, result width (signed); must equal 2*DW+1.
- TIMEOUT, 64, maximum WAIT cycles before reporting an error.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  driver can accept a request.
- REQ_A0, REQ_B0, REQ_A1, REQ_B1  in  DW each  signed operands.
- MM_START  out  1  to multiplier START.
- MM_A  out  DW  to multiplier A.
- MM_B  out  DW  to multiplier B.
- MM_OUT  in  RW  from multiplier OUT.
- MM_STROBE  in  1  from multiplier OUT_STROBE.
- RES_VALID  out  1  result present.
- RES_READY  in  1  consumer takes result.
- RES_DATA  out  RW  signed result A0*B0+A1*B1.
- RES_ERR  out  1  result is a timeout; RES_DATA=0.

Behaviour:
- One clock; reset is synchronous and active-high (RST sampled on CLK rising edge).
- All outputs decode from registered state/data only; no combinational input-to-output path.
- Reset values: REQ_READY=1 (IDLE), MM_START=0, MM_A=0, MM_B=0, RES_VALID=0, RES_DATA=0, RES_ERR=0; state=IDLE; timer=0.
- Multiplier protocol, as driven:
  - The multiplier samples A0/B0 on the first edge with START=1 and A1/B1 on the next edge.
  - It pulses OUT_STROBE for one cycle with OUT valid.
- FSM states: IDLE, SEND0, SEND1, WAIT, HOLD.
- IDLE:
  - REQ_READY=1, MM_* = 0.
  - On an edge with REQ_VALID=1, latch all four operands and go to SEND0.
- SEND0: MM_START=1, MM_A=A0, MM_B=B0; REQ_READY=0; next state SEND1 unconditionally.
- SEND1: MM_START=1, MM_A=A1, MM_B=B1; clear timer; next state WAIT.
- WAIT:
  - MM_START=0, MM_A=MM_B=0; timer increments every cycle.
  - MM_STROBE=1: capture MM_OUT into RES_DATA, set RES_ERR=0, go to HOLD.
  - Otherwise, if timer==TIMEOUT-1: set RES_DATA=0, RES_ERR=1, go to HOLD.
  - If strobe and timeout occur in the same cycle, strobe wins (valid result, no error).
- HOLD:
  - RES_VALID=1; RES_DATA and RES_ERR stable until accepted.
  - On an edge with RES_READY=1, go to IDLE.
  - No new request is accepted in HOLD (single outstanding transaction).
- Latency:
  - Request accepted at edge k: MM_START high in cycles k+1 and k+2.
  - If the strobe occurs in cycle k+2+d, RES_VALID rises at cycle k+3+d.
- MM_STROBE outside WAIT (IDLE, SEND0, SEND1, HOLD) is ignored; RES_DATA is not modified.
- RST asserted in any state, including mid-SEND or in HOLD with an unaccepted result:
  - Next edge returns to reset values and IDLE; the in-flight result is discarded.
- Arithmetic: the driver does no arithmetic; RES_DATA is MM_OUT passed through bit-exact, signed, with no truncation.
- Timer width: clog2(TIMEOUT); must not wrap before TIMEOUT-1 is reached.

Decomposition:
- Package mm_pkg holds:
  - DW/RW constants;
  - state enum {IDLE, SEND0, SEND1, WAIT, HOLD};
  - TIMEOUT default.
- One natural sub-module, mm_timeout_counter: clear, enable, and terminal-count flag at TIMEOUT-1, sync active-high reset.

Test Plan:
- Bench pairs the driver with a behavioural multiplier model (strobe 3 cycles after A1).
- Request (5,10,10,20) -> MM_START high exactly 2 cycles, carrying A=5/B=10 then A=10/B=20; RES_VALID with RES_DATA=250, RES_ERR=0.
- Requests (5,-10,10,20) and (5,10,-10,20) -> RES_DATA=150 and -150; request (-128,-128,-128,-128) -> RES_DATA=32768 (full 17-bit range).
- Model never strobes, TIMEOUT=8 -> RES_VALID exactly 8 WAIT cycles after SEND1, RES_ERR=1, RES_DATA=0.
- RES_READY held 0 for 5 cycles -> RES_VALID/RES_DATA stable; REQ_READY=0 and a REQ_VALID pulse is ignored; a spurious MM_STROBE with MM_OUT=77 leaves RES_DATA unchanged.
- RST pulsed during SEND1 -> next edge MM_START=0, REQ_READY=1, RES_VALID=0; a following request (1,2,3,4) returns 14.
- Strobe in the same cycle as timer==TIMEOUT-1 -> RES_ERR=0, RES_DATA=MM_OUT.
